updown_counter_gen: RTL and testbench

//  Parametrised up/down counter core: configurable width, step size, runtime upper limit,
//  and saturate or wrap mode, with terminal-count pulse and sticky over/underflow flags.

---
 rtl/udc_pkg.sv | 11 +
 rtl/udc_prescaler.sv | 33 +++
 rtl/updown_counter_gen.sv | 140 ++++++++++++++
 tb/tb_updown_counter_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared constants for the up/down counter core: counting modes and default widths.
package udc_pkg;

  localparam logic UDC_SAT  = 1'b0;
  localparam logic UDC_WRAP = 1'b1;

  localparam int UDC_WIDTH_DEF   = 8;
  localparam int UDC_STEP_W_DEF  = 4;
  localparam int UDC_PRESC_W_DEF = 4;

endpackage

// File: rtl/udc_prescaler.sv
// Step-rate divider: emits one tick every (div+1) enabled cycles; restarts on clr or en=0.
module udc_prescaler
  import udc_pkg::*;
#(
  parameter int PRESC_W = UDC_PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_hit;

  assign w_hit = (r_cnt == div);
  assign tick  = en && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || !en || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + P_ONE;
    end
  end

endmodule

// File: rtl/updown_counter_gen.sv
// Up/down counter core with runtime limit, saturate/wrap modes, tc pulse and sticky flags.
// Optional step prescaler is enabled by defining UDC_PRESCALE_EN.
module updown_counter_gen
  import udc_pkg::*;
#(
  parameter int WIDTH   = UDC_WIDTH_DEF,
  parameter int STEP_W  = UDC_STEP_W_DEF,
  parameter int PRESC_W = UDC_PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [STEP_W-1:0]  step,
  input  logic [WIDTH-1:0]   max_val,
  input  logic               wrap,
  input  logic               clr_flags,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [WIDTH-1:0]   count,
  output logic               at_max,
  output logic               at_zero,
  output logic               tc,
  output logic               ovf,
  output logic               udf
);

  localparam int W1 = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_udf;

  logic             w_tick;
  logic [W1-1:0]    w_cnt_ext;
  logic [W1-1:0]    w_max_ext;
  logic [W1-1:0]    w_range;
  logic [W1-1:0]    w_step_ext;
  logic [W1-1:0]    w_step_eff;
  logic [W1-1:0]    w_sum;
  logic [W1-1:0]    w_sum_wrap;
  logic [W1-1:0]    w_diff;
  logic [W1-1:0]    w_diff_wrap;

  logic [WIDTH-1:0] w_count_next;
  logic             w_tc_next;
  logic             w_set_ovf;
  logic             w_set_udf;

`ifdef UDC_PRESCALE_EN
  udc_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .div   (presc_div),
    .tick  (w_tick)
  );
`else
  logic w_unused_presc;
  assign w_unused_presc = ^presc_div;
  assign w_tick         = en;
`endif

  // All arithmetic is one bit wider than the counter so max_val+1 and count+step never overflow.
  assign w_cnt_ext   = {1'b0, r_count};
  assign w_max_ext   = {1'b0, max_val};
  assign w_range     = w_max_ext + W1'(1);
  assign w_step_ext  = W1'(step);
  assign w_step_eff  = (w_step_ext > w_range) ? w_range : w_step_ext;
  assign w_sum       = w_cnt_ext + w_step_eff;
  assign w_sum_wrap  = w_sum - w_range;
  assign w_diff      = w_cnt_ext - w_step_eff;
  assign w_diff_wrap = w_cnt_ext + w_range - w_step_eff;

  always_comb begin
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_udf    = 1'b0;

    if (load) begin
      w_count_next = (load_val > max_val) ? max_val : load_val;
    end else if (w_tick) begin
      if (r_count > max_val) begin
        // Limit was lowered below the current count: pull back silently.
        w_count_next = max_val;
      end else if (up) begin
        if (w_sum <= w_max_ext) begin
          w_count_next = w_sum[WIDTH-1:0];
        end else if (wrap == UDC_WRAP) begin
          w_count_next = w_sum_wrap[WIDTH-1:0];
          w_tc_next    = 1'b1;
        end else begin
          w_count_next = max_val;
          w_set_ovf    = 1'b1;
          w_tc_next    = 1'b1;
        end
      end else begin
        if (w_cnt_ext >= w_step_eff) begin
          w_count_next = w_diff[WIDTH-1:0];
        end else if (wrap == UDC_WRAP) begin
          w_count_next = w_diff_wrap[WIDTH-1:0];
          w_tc_next    = 1'b1;
        end else begin
          w_count_next = '0;
          w_set_udf    = 1'b1;
          w_tc_next    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
      // A new clip in the same cycle as clr_flags keeps the flag set.
      r_ovf   <= w_set_ovf | (r_ovf & ~clr_flags);
      r_udf   <= w_set_udf | (r_udf & ~clr_flags);
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign ovf     = r_ovf;
  assign udf     = r_udf;
  assign at_max  = (r_count == max_val);
  assign at_zero = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_gen.sv
// Scoreboard bench for updown_counter_gen: directed vectors push expectations, a monitor compares.
module tb_updown_counter_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load, wrap, clr_flags;
  logic [7:0] load_val, max_val;
  logic [3:0] step, presc_div;
  logic [7:0] count;
  logic       at_max, at_zero, tc, ovf, udf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      nm;
    logic [7:0] cnt;
    logic       tc, ovf, udf, amax, azero;
  } exp_t;

  exp_t sb_q[$];

  updown_counter_gen #(.WIDTH(8), .STEP_W(4), .PRESC_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .step      (step),
    .max_val   (max_val),
    .wrap      (wrap),
    .clr_flags (clr_flags),
    .presc_div (presc_div),
    .count     (count),
    .at_max    (at_max),
    .at_zero   (at_zero),
    .tc        (tc),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({count, tc, ovf, udf, at_max, at_zero} !== {e.cnt, e.tc, e.ovf, e.udf, e.amax, e.azero}) begin
        n_errors++;
        $display("FAIL %s: got count=%0d tc=%b ovf=%b udf=%b at_max=%b at_zero=%b, expected count=%0d tc=%b ovf=%b udf=%b at_max=%b at_zero=%b",
                 e.nm, count, tc, ovf, udf, at_max, at_zero, e.cnt, e.tc, e.ovf, e.udf, e.amax, e.azero);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [7:0] cnt, input logic etc,
                          input logic eovf, input logic eudf, input logic [7:0] mx);
    exp_t e;
    e.nm    = nm;
    e.cnt   = cnt;
    e.tc    = etc;
    e.ovf   = eovf;
    e.udf   = eudf;
    e.amax  = (cnt == mx);
    e.azero = (cnt == 8'd0);
    sb_q.push_back(e);
  endtask

  // Applies one cycle of inputs, then queues the state expected after that clock edge.
  task automatic cyc(input string nm, input logic i_en, input logic i_up, input logic i_load,
                     input logic [7:0] i_lv, input logic [3:0] i_step, input logic [7:0] i_max,
                     input logic i_wrap, input logic i_clr,
                     input logic [7:0] e_cnt, input logic e_tc, input logic e_ovf, input logic e_udf);
    en        = i_en;
    up        = i_up;
    load      = i_load;
    load_val  = i_lv;
    step      = i_step;
    max_val   = i_max;
    wrap      = i_wrap;
    clr_flags = i_clr;
    @(posedge clk);
    #1;
    push_exp(nm, e_cnt, e_tc, e_ovf, e_udf, i_max);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e_p;
    rst_n = 1'b0; en = 0; up = 1; load = 0; load_val = 0; step = 0;
    max_val = 8'd255; wrap = 0; clr_flags = 0; presc_div = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    //   name            en up ld lv    st  max  wr clr  cnt  tc ovf udf
    cyc("reset_state",   0, 1, 0, 8'd0, 0, 8'd255, 0, 0, 8'd0,  0, 0, 0);
    cyc("load37",        0, 1, 0+1, 8'd37, 0, 8'd255, 0, 0, 8'd37, 0, 0, 0);

    // Asynchronous reset mid-cycle must clear state before the next rising edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    push_exp("async_reset", 8'd0, 0, 0, 0, 8'd255);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc("after_reset",   0, 1, 0, 8'd0, 0, 8'd255, 0, 0, 8'd0,  0, 0, 0);

    cyc("sat_load198",   0, 1, 1, 8'd198, 0, 8'd200, 0, 0, 8'd198, 0, 0, 0);
    cyc("sat_up_clip",   1, 1, 0, 8'd0, 5, 8'd200, 0, 0, 8'd200, 1, 1, 0);
    cyc("sat_up_again",  1, 1, 0, 8'd0, 5, 8'd200, 0, 0, 8'd200, 1, 1, 0);
    cyc("sat_idle",      0, 1, 0, 8'd0, 5, 8'd200, 0, 0, 8'd200, 0, 1, 0);
    cyc("sat_clr_ovf",   0, 1, 0, 8'd0, 5, 8'd200, 0, 1, 8'd200, 0, 0, 0);

    cyc("wrap_load8",    0, 1, 1, 8'd8, 3, 8'd9, 1, 0, 8'd8, 0, 0, 0);
    cyc("wrap_up",       1, 1, 0, 8'd0, 3, 8'd9, 1, 0, 8'd1, 1, 0, 0);
    cyc("wrap_down",     1, 0, 0, 8'd0, 3, 8'd9, 1, 0, 8'd8, 1, 0, 0);
    cyc("wrap_idle",     0, 0, 0, 8'd0, 3, 8'd9, 1, 0, 8'd8, 0, 0, 0);

    cyc("prio_load",     1, 1, 1, 8'd250, 1, 8'd200, 0, 0, 8'd200, 0, 0, 0);
    cyc("prio_clamp",    1, 1, 0, 8'd0, 1, 8'd50, 0, 0, 8'd50, 0, 0, 0);

    cyc("flag_load2",    0, 0, 1, 8'd2, 4, 8'd50, 0, 0, 8'd2, 0, 0, 0);
    cyc("flag_down_sat", 1, 0, 0, 8'd0, 4, 8'd50, 0, 0, 8'd0, 1, 0, 1);
    cyc("flag_set_wins", 1, 0, 0, 8'd0, 4, 8'd50, 0, 1, 8'd0, 1, 0, 1);
    cyc("flag_clr",      0, 0, 0, 8'd0, 4, 8'd50, 0, 1, 8'd0, 0, 0, 0);

    cyc("max0_wrap_up",  1, 1, 0, 8'd0, 5, 8'd0, 1, 0, 8'd0, 1, 0, 0);
    cyc("bigstep_load5", 0, 1, 1, 8'd5, 15, 8'd9, 1, 0, 8'd5, 0, 0, 0);
    cyc("bigstep_wrap",  1, 1, 0, 8'd0, 15, 8'd9, 1, 0, 8'd5, 1, 0, 0);

    presc_div = 4'd3;
    cyc("presc_load0",   0, 1, 1, 8'd0, 1, 8'd255, 0, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
`ifdef UDC_PRESCALE_EN
      e_p = 8'(k / 4);
`else
      e_p = 8'(k);
`endif
      cyc($sformatf("presc_cycle%0d", k), 1, 1, 0, 8'd0, 1, 8'd255, 0, 0, e_p, 0, 0, 0);
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
